// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-aligned word swap.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always lit).
module seg7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      load_valid,
    input  logic [4*NUM_DIGITS-1:0]   load_data,
    output logic                      load_ready,
    output logic [3:0]                dig_code,
    output logic [NUM_DIGITS-1:0]     dig_sel,
    output logic                      blank,
    output logic                      frame_done
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] BlankLast = DIV_W'(BLANK_CYCLES - 1);
    localparam logic [DIV_W-1:0] ShowLast  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] CntOne    = DIV_W'(1);
    localparam logic [IdxW-1:0]  IdxLast   = IdxW'(NUM_DIGITS - 1);
    localparam logic [IdxW-1:0]  IdxOne    = IdxW'(1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBlank = 2'd1;
    localparam logic [1:0] StShow  = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [DIV_W-1:0]          cnt_q, cnt_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   active_q, active_d;
    logic [4*NUM_DIGITS-1:0]   pend_q, pend_d;
    logic                      pend_full_q, pend_full_d;
    logic                      load_ready_q, load_ready_d;
    logic [3:0]                dig_code_q, dig_code_d;
    logic [NUM_DIGITS-1:0]     dig_sel_q, dig_sel_d;
    logic                      blank_q, blank_d;
    logic                      frame_done_q, frame_done_d;
    logic                      boundary;
    logic                      xfer;
    logic [3:0]                cur_code;
    logic                      lit_ok;

    // Scan sequencing and pending-to-active transfer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        boundary    = 1'b0;
        xfer        = 1'b0;
        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    idx_d   = '0;
                    xfer    = 1'b1;
                end
                StBlank: begin
                    if (cnt_q == BlankLast) begin
                        state_d = StShow;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StShow: begin
                    if (cnt_q == ShowLast) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                        if (idx_q == IdxLast) begin
                            idx_d    = '0;
                            boundary = 1'b1;
                            xfer     = 1'b1;
                        end else begin
                            idx_d = idx_q + IdxOne;
                        end
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
        if (xfer && pend_full_q) begin
            active_d    = pend_q;
            pend_full_d = 1'b0;
        end
        // Ready only when pending is empty, so accept and transfer never collide
        if (load_valid && load_ready_q) begin
            pend_d      = load_data;
            pend_full_d = 1'b1;
        end
        load_ready_d = ~pend_full_d;
    end

    always_comb begin
        cur_code = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) cur_code = active_q[4*i +: 4];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] dark;
    logic                  zero_above;

    // dark[i]: digit i and every digit above it are zero
    always_comb begin
        dark       = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (active_q[4*i +: 4] == 4'd0);
            dark[i]    = zero_above;
        end
        lit_ok = ~dark[idx_q];
    end
`else
    assign lit_ok = 1'b1;
`endif

    always_comb begin
        dig_sel_d  = '0;
        dig_code_d = '0;
        if (enable && state_q != StIdle) begin
            dig_code_d = cur_code;
            if (state_q == StShow && lit_ok) begin
                dig_sel_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
            end
        end
        blank_d      = (dig_sel_d == '0);
        frame_done_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            load_ready_q <= 1'b1;
            dig_code_q   <= '0;
            dig_sel_q    <= '0;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            load_ready_q <= load_ready_d;
            dig_code_q   <= dig_code_d;
            dig_sel_q    <= dig_sel_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign dig_code   = dig_code_q;
    assign dig_sel    = dig_sel_q;
    assign blank      = blank_q;
    assign frame_done = frame_done_q;

endmodule
